// File: rtl/trdb_pkg.sv
// Shared trace-packet types for the priority decode and arbitration path.
// Formats, subformats and the per-channel packet request bundle.
package trdb_pkg;

   typedef enum logic [1:0] {
      F_OPT_EXT     = 2'h0,
      F_BRANCH_FULL = 2'h1,
      F_ADDR_ONLY   = 2'h2,
      F_SYNC        = 2'h3
   } trdb_format_t;

   typedef enum logic [1:0] {
      SF_START     = 2'h0,
      SF_EXCEPTION = 2'h1,
      SF_CONTEXT   = 2'h2,
      SF_UNDEF     = 2'h3
   } trdb_subformat_t;

   typedef struct packed {
      logic            valid;
      trdb_format_t    format;
      trdb_subformat_t subformat;
   } trdb_pkt_req_t;

   function automatic int chan_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/trdb_priority_arb_if.sv
// Packet request handshake between the arbiter and the packet emitter.
// Master drives the request, slave answers with ready.
interface trdb_priority_arb_if
   import trdb_pkg::*;
#(
   parameter int NCH = 2
) ();

   localparam int CW = chan_w(NCH);

   logic            valid;
   logic            ready;
   trdb_format_t    format;
   trdb_subformat_t subformat;
   logic [CW-1:0]   chan;

   modport master (
      output valid, format, subformat, chan,
      input  ready
   );

   modport slave (
      input  valid, format, subformat, chan,
      output ready
   );

endinterface

// File: rtl/trdb_priority_dec.sv
// Single-channel trace event decode into a packet request.
// Earlier rules shadow later ones; resync promotion only upgrades rules 4-7.
module trdb_priority_dec
   import trdb_pkg::*;
(
   input  logic          lc_exception_i,
   input  logic          tc_first_qualified_i,
   input  logic          tc_unhalted_i,
   input  logic          tc_privchange_i,
   input  logic          tc_context_change_i,
   input  logic          lc_u_discontinuity_i,
   input  logic          nc_halt_i,
   input  logic          nc_exception_i,
   input  logic          nc_privchange_i,
   input  logic          nc_unqualified_i,
   input  logic          branch_map_full_i,
   input  logic          branch_map_empty_i,
   input  logic          exc_sync_i,
   input  logic          resync_pend_i,
   output trdb_pkt_req_t req_o
);

   logic addr_ev;
   logic low_ev;
   trdb_format_t addr_fmt;

   assign addr_ev = lc_u_discontinuity_i | nc_halt_i | nc_exception_i
                  | nc_privchange_i | nc_unqualified_i;
   assign low_ev = addr_ev | branch_map_full_i | tc_context_change_i;
   assign addr_fmt = branch_map_empty_i ? F_ADDR_ONLY : F_BRANCH_FULL;

   always_comb begin
      req_o = '{valid: 1'b0, format: F_ADDR_ONLY, subformat: SF_UNDEF};
      if (lc_exception_i && !exc_sync_i) begin
         req_o = '{valid: 1'b1, format: F_SYNC, subformat: SF_EXCEPTION};
      end else if (tc_first_qualified_i || tc_unhalted_i || tc_privchange_i) begin
         req_o = '{valid: 1'b1, format: F_SYNC, subformat: SF_START};
      end else if (resync_pend_i && low_ev) begin
         req_o = '{valid: 1'b1, format: F_SYNC, subformat: SF_START};
      end else if (addr_ev) begin
         req_o = '{valid: 1'b1, format: addr_fmt, subformat: SF_UNDEF};
      end else if (branch_map_full_i) begin
         req_o = '{valid: 1'b1, format: F_BRANCH_FULL, subformat: SF_UNDEF};
      end else if (tc_context_change_i) begin
         req_o = '{valid: 1'b1, format: F_SYNC, subformat: SF_CONTEXT};
      end
   end

endmodule

// File: rtl/trdb_priority_arb.sv
// Multi-channel packet priority decode with round-robin arbitration
// into one registered valid/ready request toward the packet emitter.
module trdb_priority_arb
   import trdb_pkg::*;
#(
   parameter int NCH        = 2,
   parameter int RESYNC_MAX = 255
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [NCH-1:0]   lc_exception_i,
   input  logic [NCH-1:0]   tc_first_qualified_i,
   input  logic [NCH-1:0]   tc_unhalted_i,
   input  logic [NCH-1:0]   tc_privchange_i,
   input  logic [NCH-1:0]   tc_context_change_i,
   input  logic [NCH-1:0]   lc_u_discontinuity_i,
   input  logic [NCH-1:0]   nc_halt_i,
   input  logic [NCH-1:0]   nc_exception_i,
   input  logic [NCH-1:0]   nc_privchange_i,
   input  logic [NCH-1:0]   nc_unqualified_i,
   input  logic [NCH-1:0]   branch_map_full_i,
   input  logic [NCH-1:0]   branch_map_empty_i,
   output logic [NCH-1:0]   accept_o,
   trdb_priority_arb_if.master out_if
);

   localparam int CW   = chan_w(NCH);
   localparam int CNTW = $clog2(RESYNC_MAX + 1);

   trdb_pkt_req_t   req [NCH];
   logic [NCH-1:0]  req_v;
   logic [NCH-1:0]  resync_pend;
   logic [CNTW-1:0] cnt_q [NCH];
   logic [CNTW-1:0] cnt_d [NCH];
   logic [NCH-1:0]  exc_q, exc_d;
   logic [CW-1:0]   rr_q, rr_d;
   logic            valid_q, valid_d;
   trdb_format_t    fmt_q, fmt_d;
   trdb_subformat_t sf_q, sf_d;
   logic [CW-1:0]   chan_q, chan_d;
   logic [CW-1:0]   grant;
   logic            found;
   logic            can_take;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign resync_pend[c] = (cnt_q[c] == CNTW'(RESYNC_MAX));
      assign req_v[c] = req[c].valid;

      trdb_priority_dec u_dec (
         .lc_exception_i       (lc_exception_i[c]),
         .tc_first_qualified_i (tc_first_qualified_i[c]),
         .tc_unhalted_i        (tc_unhalted_i[c]),
         .tc_privchange_i      (tc_privchange_i[c]),
         .tc_context_change_i  (tc_context_change_i[c]),
         .lc_u_discontinuity_i (lc_u_discontinuity_i[c]),
         .nc_halt_i            (nc_halt_i[c]),
         .nc_exception_i       (nc_exception_i[c]),
         .nc_privchange_i      (nc_privchange_i[c]),
         .nc_unqualified_i     (nc_unqualified_i[c]),
         .branch_map_full_i    (branch_map_full_i[c]),
         .branch_map_empty_i   (branch_map_empty_i[c]),
         .exc_sync_i           (exc_q[c]),
         .resync_pend_i        (resync_pend[c]),
         .req_o                (req[c])
      );
   end

   // Search starts at rr_q and wraps, so the last winner goes to the back.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (!found && req_v[(int'(rr_q) + i) % NCH]) begin
            found = 1'b1;
            grant = CW'((int'(rr_q) + i) % NCH);
         end
      end
   end

   assign can_take = rst_ni && (!valid_q || out_if.ready);

   always_comb begin
      valid_d  = valid_q;
      fmt_d    = fmt_q;
      sf_d     = sf_q;
      chan_d   = chan_q;
      rr_d     = rr_q;
      cnt_d    = cnt_q;
      exc_d    = exc_q & lc_exception_i;
      accept_o = '0;
      if (can_take) begin
         valid_d = found;
         if (found) begin
            fmt_d           = req[grant].format;
            sf_d            = req[grant].subformat;
            chan_d          = grant;
            accept_o[grant] = 1'b1;
            rr_d            = (grant == CW'(NCH - 1)) ? '0 : grant + 1'b1;
            exc_d[grant]    = (req[grant].subformat == SF_EXCEPTION);
            if (req[grant].format == F_SYNC) begin
               cnt_d[grant] = '0;
            end else if (!resync_pend[grant]) begin
               cnt_d[grant] = cnt_q[grant] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         fmt_q   <= F_ADDR_ONLY;
         sf_q    <= SF_UNDEF;
         chan_q  <= '0;
         rr_q    <= '0;
         exc_q   <= '0;
         for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
      end else begin
         valid_q <= valid_d;
         fmt_q   <= fmt_d;
         sf_q    <= sf_d;
         chan_q  <= chan_d;
         rr_q    <= rr_d;
         exc_q   <= exc_d;
         for (int c = 0; c < NCH; c++) cnt_q[c] <= cnt_d[c];
      end
   end

   assign out_if.valid     = valid_q;
   assign out_if.format    = fmt_q;
   assign out_if.subformat = sf_q;
   assign out_if.chan      = chan_q;

endmodule
